// File: rtl/wb_write_queue.sv
// Writeback queue in front of the 32x32 register file write port.
// Buffers writes in order, drains one per cycle, and offers decode a pending/forwarding view.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [4:0]    wb_reg,
   input  logic [31:0]   wb_data,
   input  logic          drain_en,
   output logic          RegWrite,
   output logic [4:0]    WriteReg,
   output logic [31:0]   WriteData,
   input  logic [4:0]    chk_reg1,
   input  logic [4:0]    chk_reg2,
   output logic          pend1,
   output logic          pend2,
   output logic [31:0]   fwd_data1,
   output logic [31:0]   fwd_data2,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;

   logic [4:0]    reg_mem  [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic          enq;
   logic          deq;

   assign wb_ready = (count_q != FULL);
   // Writes to r0 complete the handshake but never occupy a slot.
   assign enq      = wb_valid && wb_ready && (wb_reg != 5'd0);
   assign deq      = drain_en && (count_q != '0);

   assign RegWrite  = deq;
   assign WriteReg  = (count_q != '0) ? reg_mem[head_q]  : 5'd0;
   assign WriteData = (count_q != '0) ? data_mem[head_q] : 32'd0;
   assign count     = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq) begin
         head_d = head_q + 1'b1;
      end
      if (enq) begin
         tail_d = tail_q + 1'b1;
      end
      if (enq && !deq) begin
         count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         reg_mem[tail_q]  <= wb_reg;
         data_mem[tail_q] <= wb_data;
      end
   end

   // Walk entries oldest to youngest so the last match is the newest value.
   always_comb begin
      logic [AW-1:0] idx;
      logic          live;
      idx       = '0;
      live      = 1'b0;
      pend1     = 1'b0;
      pend2     = 1'b0;
      fwd_data1 = 32'd0;
      fwd_data2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx  = head_q + AW'(i);
         live = ((AW+1)'(i) < count_q);
         if (live && (chk_reg1 != 5'd0) && (reg_mem[idx] == chk_reg1)) begin
            pend1     = 1'b1;
            fwd_data1 = data_mem[idx];
         end
         if (live && (chk_reg2 != 5'd0) && (reg_mem[idx] == chk_reg2)) begin
            pend2     = 1'b1;
            fwd_data2 = data_mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vector table, async reset corner, streaming wrap,
// and randomized traffic against a queue-based reference model.
module tb_wb_write_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk;
   logic          reset;
   logic          wb_valid;
   logic          wb_ready;
   logic [4:0]    wb_reg;
   logic [31:0]   wb_data;
   logic          drain_en;
   logic          RegWrite;
   logic [4:0]    WriteReg;
   logic [31:0]   WriteData;
   logic [4:0]    chk_reg1;
   logic [4:0]    chk_reg2;
   logic          pend1;
   logic          pend2;
   logic [31:0]   fwd_data1;
   logic [31:0]   fwd_data2;
   logic [AW:0]   count;

   int checks = 0;
   int errors = 0;

   wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .drain_en  (drain_en),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .chk_reg1  (chk_reg1),
      .chk_reg2  (chk_reg2),
      .pend1     (pend1),
      .pend2     (pend2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        wv;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        de;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        e_rdy;
      logic        e_rw;
      logic [4:0]  e_wreg;
      logic [31:0] e_wdata;
      logic        e_p1;
      logic [31:0] e_f1;
      logic        e_p2;
      logic [31:0] e_f2;
      logic [2:0]  e_cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic wv, input logic [4:0] wr, input logic [31:0] wd, input logic de,
      input logic [4:0] c1, input logic [4:0] c2,
      input logic e_rdy, input logic e_rw, input logic [4:0] e_wreg, input logic [31:0] e_wdata,
      input logic e_p1, input logic [31:0] e_f1, input logic e_p2, input logic [31:0] e_f2,
      input logic [2:0] e_cnt);
      vec_t v;
      v.wv = wv; v.wr = wr; v.wd = wd; v.de = de; v.c1 = c1; v.c2 = c2;
      v.e_rdy = e_rdy; v.e_rw = e_rw; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
      v.e_p1 = e_p1; v.e_f1 = e_f1; v.e_p2 = e_p2; v.e_f2 = e_f2; v.e_cnt = e_cnt;
      return v;
   endfunction

   // Reference model: plain FIFO of {reg,data}.
   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;
   ent_t mq[$];

   // Applies one cycle of inputs, compares against the model before the edge, then advances.
   task automatic model_cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                              input logic de, input logic [4:0] c1, input logic [4:0] c2);
      logic        e_rdy, e_rw, e_p1, e_p2;
      logic [4:0]  e_wreg;
      logic [31:0] e_wdata, e_f1, e_f2;
      ent_t        ne;
      wb_valid = wv; wb_reg = wr; wb_data = wd; drain_en = de; chk_reg1 = c1; chk_reg2 = c2;
      e_rdy   = (mq.size() != DEPTH);
      e_rw    = de && (mq.size() != 0);
      e_wreg  = (mq.size() != 0) ? mq[0].r : 5'd0;
      e_wdata = (mq.size() != 0) ? mq[0].d : 32'd0;
      e_p1 = 1'b0; e_f1 = 32'd0; e_p2 = 1'b0; e_f2 = 32'd0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
         if (!e_p1 && c1 != 5'd0 && mq[k].r == c1) begin e_p1 = 1'b1; e_f1 = mq[k].d; end
         if (!e_p2 && c2 != 5'd0 && mq[k].r == c2) begin e_p2 = 1'b1; e_f2 = mq[k].d; end
      end
      @(negedge clk);
      chk("m_ready",  {31'd0, wb_ready}, {31'd0, e_rdy});
      chk("m_regwr",  {31'd0, RegWrite}, {31'd0, e_rw});
      chk("m_wreg",   {27'd0, WriteReg}, {27'd0, e_wreg});
      chk("m_wdata",  WriteData, e_wdata);
      chk("m_count",  {29'd0, count}, mq.size());
      chk("m_pend1",  {31'd0, pend1}, {31'd0, e_p1});
      chk("m_fwd1",   fwd_data1, e_f1);
      chk("m_pend2",  {31'd0, pend2}, {31'd0, e_p2});
      chk("m_fwd2",   fwd_data2, e_f2);
      if (e_rw) void'(mq.pop_front());
      if (wv && e_rdy && wr != 5'd0) begin
         ne.r = wr; ne.d = wd;
         mq.push_back(ne);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t vt[20];

   initial begin
      reset = 1'b1;
      wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; drain_en = 1'b0;
      chk_reg1 = 5'd0; chk_reg2 = 5'd0;

      //        wv  wr     wd            de  c1     c2     rdy rw  wreg   wdata         p1  f1            p2  f2     cnt
      vt[0]  = mk(1, 5'd5, 32'h1111_1111, 1, 5'd5, 5'd0, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  3'd0);
      vt[1]  = mk(0, 5'd0, 32'h0,         1, 5'd5, 5'd0, 1, 1, 5'd5, 32'h1111_1111,1, 32'h1111_1111,0, 32'h0,  3'd1);
      vt[2]  = mk(0, 5'd0, 32'h0,         1, 5'd5, 5'd0, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  3'd0);
      vt[3]  = mk(1, 5'd1, 32'hA,         0, 5'd1, 5'd0, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  3'd0);
      vt[4]  = mk(1, 5'd2, 32'hB,         0, 5'd1, 5'd0, 1, 0, 5'd1, 32'hA,        1, 32'hA,        0, 32'h0,  3'd1);
      vt[5]  = mk(1, 5'd3, 32'hC,         0, 5'd1, 5'd0, 1, 0, 5'd1, 32'hA,        1, 32'hA,        0, 32'h0,  3'd2);
      vt[6]  = mk(1, 5'd4, 32'hD,         0, 5'd1, 5'd0, 1, 0, 5'd1, 32'hA,        1, 32'hA,        0, 32'h0,  3'd3);
      vt[7]  = mk(1, 5'd9, 32'hE,         0, 5'd4, 5'd0, 0, 0, 5'd1, 32'hA,        1, 32'hD,        0, 32'h0,  3'd4);
      vt[8]  = mk(1, 5'd9, 32'hE,         1, 5'd9, 5'd0, 0, 1, 5'd1, 32'hA,        0, 32'h0,        0, 32'h0,  3'd4);
      vt[9]  = mk(0, 5'd0, 32'h0,         1, 5'd0, 5'd0, 1, 1, 5'd2, 32'hB,        0, 32'h0,        0, 32'h0,  3'd3);
      vt[10] = mk(0, 5'd0, 32'h0,         1, 5'd0, 5'd0, 1, 1, 5'd3, 32'hC,        0, 32'h0,        0, 32'h0,  3'd2);
      vt[11] = mk(0, 5'd0, 32'h0,         1, 5'd0, 5'd0, 1, 1, 5'd4, 32'hD,        0, 32'h0,        0, 32'h0,  3'd1);
      vt[12] = mk(0, 5'd0, 32'h0,         1, 5'd0, 5'd0, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  3'd0);
      vt[13] = mk(1, 5'd7, 32'h10,        0, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  3'd0);
      vt[14] = mk(1, 5'd7, 32'h20,        0, 5'd7, 5'd0, 1, 0, 5'd7, 32'h10,       1, 32'h10,       0, 32'h0,  3'd1);
      vt[15] = mk(1, 5'd0, 32'hDEAD,      0, 5'd7, 5'd0, 1, 0, 5'd7, 32'h10,       1, 32'h20,       0, 32'h0,  3'd2);
      vt[16] = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 1, 0, 5'd7, 32'h10,       0, 32'h0,        1, 32'h20, 3'd2);
      vt[17] = mk(0, 5'd0, 32'h0,         1, 5'd7, 5'd0, 1, 1, 5'd7, 32'h10,       1, 32'h20,       0, 32'h0,  3'd2);
      vt[18] = mk(0, 5'd0, 32'h0,         1, 5'd7, 5'd0, 1, 1, 5'd7, 32'h20,       1, 32'h20,       0, 32'h0,  3'd1);
      vt[19] = mk(0, 5'd0, 32'h0,         1, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  3'd0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_regwr", {31'd0, RegWrite}, 32'd0);
      chk("rst_wreg",  {27'd0, WriteReg}, 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk("rst_ready", {31'd0, wb_ready}, 32'd1);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_pend1", {31'd0, pend1}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 20; v++) begin
         wb_valid = vt[v].wv; wb_reg = vt[v].wr; wb_data = vt[v].wd;
         drain_en = vt[v].de; chk_reg1 = vt[v].c1; chk_reg2 = vt[v].c2;
         @(negedge clk);
         chk($sformatf("v%0d_ready", v), {31'd0, wb_ready}, {31'd0, vt[v].e_rdy});
         chk($sformatf("v%0d_regwr", v), {31'd0, RegWrite}, {31'd0, vt[v].e_rw});
         chk($sformatf("v%0d_wreg", v),  {27'd0, WriteReg}, {27'd0, vt[v].e_wreg});
         chk($sformatf("v%0d_wdata", v), WriteData, vt[v].e_wdata);
         chk($sformatf("v%0d_pend1", v), {31'd0, pend1}, {31'd0, vt[v].e_p1});
         chk($sformatf("v%0d_fwd1", v),  fwd_data1, vt[v].e_f1);
         chk($sformatf("v%0d_pend2", v), {31'd0, pend2}, {31'd0, vt[v].e_p2});
         chk($sformatf("v%0d_fwd2", v),  fwd_data2, vt[v].e_f2);
         chk($sformatf("v%0d_count", v), {29'd0, count}, {29'd0, vt[v].e_cnt});
         @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of a drain with three entries queued.
      mq.delete();
      model_cycle(1, 5'd3, 32'h33, 0, 5'd0, 5'd0);
      model_cycle(1, 5'd4, 32'h44, 0, 5'd0, 5'd0);
      model_cycle(1, 5'd6, 32'h66, 0, 5'd0, 5'd0);
      wb_valid = 1'b0; drain_en = 1'b1; chk_reg1 = 5'd4;
      #2;
      chk("pre_arst_regwr", {31'd0, RegWrite}, 32'd1);
      reset = 1'b1;
      #1;
      chk("arst_count", {29'd0, count}, 32'd0);
      chk("arst_regwr", {31'd0, RegWrite}, 32'd0);
      chk("arst_ready", {31'd0, wb_ready}, 32'd1);
      chk("arst_pend1", {31'd0, pend1}, 32'd0);
      chk("arst_fwd1",  fwd_data1, 32'd0);
      mq.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      drain_en = 1'b0;

      // Continuous stream with draining enabled; ten writes wrap the pointers.
      for (int s = 0; s < 10; s++) begin
         model_cycle(1, 5'(s + 1), $urandom, 1, 5'(s + 1), 5'(s));
         chk($sformatf("stream%0d_cnt_le1", s), {31'd0, (count <= 3'd1)}, 32'd1);
      end
      for (int s = 0; s < 3; s++) model_cycle(0, 5'd0, 32'd0, 1, 5'd0, 5'd0);

      for (int r = 0; r < 400; r++) begin
         model_cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
